stopwatch_counter: RTL and testbench

Minutes:seconds BCD stopwatch core driven by the square-wave enables from the clock divider stage. Samples the 1 Hz count clock and 2 Hz adjust clock as levels in the system clock domain, detects their rising edges internally, and advances or adjusts four BCD digits. Feeds the seven-segment display multiplexer.

---
 rtl/stopwatch_counter.sv | 147 ++++++++++++++
 tb/tb_stopwatch_counter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_counter
//   Minutes:seconds BCD stopwatch core. The 1 Hz count clock, 2 Hz adjust
//   clock and debounced pause level are sampled as levels in the clk domain.
//   Their rising edges become one-cycle ticks that advance, adjust or pause
//   four BCD digits.
//
// Parameters
//   START_PAUSED : value of paused after reset
//   ROLL_OVER    : 1 = 59:59 wraps to 00:00 when counting, 0 = holds at 59:59
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   countclk  in   1 Hz square wave (level, synchronous to clk)
//   adjclk    in   2 Hz square wave (level, synchronous to clk)
//   adj       in   1 = adjust mode
//   sel       in   adjust target: 0 = minutes, 1 = seconds
//   pause     in   debounced level; each rising edge toggles paused
//   min_tens, min_ones, sec_tens, sec_ones  out  BCD digits (registered)
//   paused    out  1 while counting is frozen (registered)
//
// Optional feature macro: STOPWATCH_BLINK_EN
//   Adds input blinkclk and outputs blank_min / blank_sec. In adjust mode the
//   field selected by sel blanks in step with blinkclk (one cycle late).
// ---------------------------------------------------------------------------
module stopwatch_counter #(
  parameter bit START_PAUSED = 1'b0,
  parameter bit ROLL_OVER    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       countclk,
  input  logic       adjclk,
  input  logic       adj,
  input  logic       sel,
  input  logic       pause,
`ifdef STOPWATCH_BLINK_EN
  input  logic       blinkclk,
  output logic       blank_min,
  output logic       blank_sec,
`endif
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       paused
);

  logic       countclk_q, adjclk_q, pause_q;
  logic       cnt_tick, adj_tick, pause_edge;
  logic       run_cnt, run_adj;
  logic       at_max, sec_wrap;
  logic [3:0] min_tens_next, min_ones_next, sec_tens_next, sec_ones_next;

  assign cnt_tick   = countclk & ~countclk_q;
  assign adj_tick   = adjclk & ~adjclk_q;
  assign pause_edge = pause & ~pause_q;

  // Gating uses the registered paused value: a tick coinciding with the
  // pausing edge still counts, one coinciding with the unpausing edge is lost.
  assign run_cnt = cnt_tick & ~adj & ~paused;
  assign run_adj = adj_tick &  adj & ~paused;

  assign sec_wrap = (sec_tens == 4'd5) && (sec_ones == 4'd9);
  assign at_max   = sec_wrap && (min_tens == 4'd5) && (min_ones == 4'd9);

  always_comb begin
    min_tens_next = min_tens;
    min_ones_next = min_ones;
    sec_tens_next = sec_tens;
    sec_ones_next = sec_ones;

    if (run_cnt) begin
      // Without roll-over the counter parks at 59:59.
      if (!(at_max && !ROLL_OVER)) begin
        if (sec_ones >= 4'd9) begin
          sec_ones_next = 4'd0;
          sec_tens_next = (sec_tens >= 4'd5) ? 4'd0 : sec_tens + 4'd1;
        end else begin
          sec_ones_next = sec_ones + 4'd1;
        end
        // Minutes advance only on the 59->00 second carry; 59 minutes wraps.
        if (sec_wrap) begin
          if (min_ones >= 4'd9) begin
            min_ones_next = 4'd0;
            min_tens_next = (min_tens >= 4'd5) ? 4'd0 : min_tens + 4'd1;
          end else begin
            min_ones_next = min_ones + 4'd1;
          end
        end
      end
    end else if (run_adj) begin
      // Adjusting one field never carries into the other.
      if (sel) begin
        if (sec_ones >= 4'd9) begin
          sec_ones_next = 4'd0;
          sec_tens_next = (sec_tens >= 4'd5) ? 4'd0 : sec_tens + 4'd1;
        end else begin
          sec_ones_next = sec_ones + 4'd1;
        end
      end else begin
        if (min_ones >= 4'd9) begin
          min_ones_next = 4'd0;
          min_tens_next = (min_tens >= 4'd5) ? 4'd0 : min_tens + 4'd1;
        end else begin
          min_ones_next = min_ones + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countclk_q <= 1'b0;
      adjclk_q   <= 1'b0;
      pause_q    <= 1'b0;
      paused     <= START_PAUSED;
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
    end else begin
      countclk_q <= countclk;
      adjclk_q   <= adjclk;
      pause_q    <= pause;
      if (pause_edge) paused <= ~paused;
      min_tens   <= min_tens_next;
      min_ones   <= min_ones_next;
      sec_tens   <= sec_tens_next;
      sec_ones   <= sec_ones_next;
    end
  end

`ifdef STOPWATCH_BLINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
    end else begin
      blank_min <= adj & ~sel & blinkclk;
      blank_sec <= adj &  sel & blinkclk;
    end
  end
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_counter
//   Directed self-checking bench for stopwatch_counter. Two instances share
//   all stimulus: dut_a uses the default configuration (roll-over), dut_b
//   holds at 59:59. Digits are compared as a packed 16-bit mm:ss value.
// ---------------------------------------------------------------------------
module tb_stopwatch_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic countclk = 1'b0, adjclk = 1'b0, adj = 1'b0, sel = 1'b0, pause = 1'b0;
  logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
  logic a_paused, b_paused;
`ifdef STOPWATCH_BLINK_EN
  logic blinkclk = 1'b0;
  logic a_bmin, a_bsec, b_bmin, b_bsec;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  stopwatch_counter dut_a (
    .clk(clk), .rst(rst), .countclk(countclk), .adjclk(adjclk),
    .adj(adj), .sel(sel), .pause(pause),
`ifdef STOPWATCH_BLINK_EN
    .blinkclk(blinkclk), .blank_min(a_bmin), .blank_sec(a_bsec),
`endif
    .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
    .paused(a_paused)
  );

  stopwatch_counter #(.START_PAUSED(1'b0), .ROLL_OVER(1'b0)) dut_b (
    .clk(clk), .rst(rst), .countclk(countclk), .adjclk(adjclk),
    .adj(adj), .sel(sel), .pause(pause),
`ifdef STOPWATCH_BLINK_EN
    .blinkclk(blinkclk), .blank_min(b_bmin), .blank_sec(b_bsec),
`endif
    .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
    .paused(b_paused)
  );

  wire [15:0] t_a = {a_mt, a_mo, a_st, a_so};
  wire [15:0] t_b = {b_mt, b_mo, b_st, b_so};

  // Elapsed seconds -> expected mm:ss BCD.
  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = (secs / 60) % 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic cnt_pulse();
    countclk = 1'b1;
    @(posedge clk); #1;
    countclk = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic adj_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      adjclk = 1'b1;
      @(posedge clk); #1;
      adjclk = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    countclk = 0; adjclk = 0; adj = 0; sel = 0; pause = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (t_a !== 16'h0000) begin fails++; $display("FAIL reset_digits_a got %h exp 0000", t_a); end
    checks++;
    if (t_b !== 16'h0000) begin fails++; $display("FAIL reset_digits_b got %h exp 0000", t_b); end
    checks++;
    if (a_paused !== 1'b0) begin fails++; $display("FAIL reset_paused got %b exp 0", a_paused); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: digits=%h paused=%b", t_a, a_paused);
  endtask

  task automatic test_count60();
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      countclk = 1'b1;
      // No combinational path: value must not move before the edge.
      checks++;
      if (t_a !== to_bcd(i - 1)) begin
        fails++; $display("FAIL count_pre_%0d got %h exp %h", i, t_a, to_bcd(i - 1));
      end
      @(posedge clk); #1;
      checks++;
      if (t_a !== to_bcd(i)) begin
        fails++; $display("FAIL count_step_%0d got %h exp %h", i, t_a, to_bcd(i));
      end
      countclk = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (t_a !== 16'h0100) begin fails++; $display("FAIL count60 got %h exp 0100", t_a); end
    $display("count60: digits=%h", t_a);
  endtask

  task automatic test_rollover();
    do_reset();
    adj = 1'b1; sel = 1'b0;
    adj_pulses(59);
    sel = 1'b1;
    adj_pulses(58);
    adj = 1'b0;
    checks++;
    if (t_a !== 16'h5958) begin fails++; $display("FAIL preload_a got %h exp 5958", t_a); end
    checks++;
    if (t_b !== 16'h5958) begin fails++; $display("FAIL preload_b got %h exp 5958", t_b); end
    cnt_pulse();
    checks++;
    if (t_a !== 16'h5959) begin fails++; $display("FAIL roll_5959_a got %h exp 5959", t_a); end
    cnt_pulse();
    checks++;
    if (t_a !== 16'h0000) begin fails++; $display("FAIL roll_wrap_a got %h exp 0000", t_a); end
    checks++;
    if (t_b !== 16'h5959) begin fails++; $display("FAIL roll_hold_b got %h exp 5959", t_b); end
    cnt_pulse();
    checks++;
    if (t_a !== 16'h0001) begin fails++; $display("FAIL roll_after_a got %h exp 0001", t_a); end
    checks++;
    if (t_b !== 16'h5959) begin fails++; $display("FAIL roll_hold2_b got %h exp 5959", t_b); end
    $display("rollover: a=%h b=%h", t_a, t_b);
  endtask

  task automatic test_adjust();
    do_reset();
    adj = 1'b1; sel = 1'b0;
    adj_pulses(58);
    sel = 1'b1;
    adj_pulses(30);
    checks++;
    if (t_a !== 16'h5830) begin fails++; $display("FAIL adj_preload got %h exp 5830", t_a); end
    sel = 1'b0;
    // countclk edges alongside adjclk must change nothing.
    for (int i = 0; i < 3; i++) begin
      adjclk = 1'b1; countclk = 1'b1;
      @(posedge clk); #1;
      adjclk = 1'b0; countclk = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (t_a !== 16'h0130) begin fails++; $display("FAIL adj_min_wrap got %h exp 0130", t_a); end
    sel = 1'b1;
    adj_pulses(28);
    checks++;
    if (t_a !== 16'h0158) begin fails++; $display("FAIL adj_sec_preload got %h exp 0158", t_a); end
    for (int i = 0; i < 3; i++) begin
      adjclk = 1'b1; countclk = 1'b1;
      @(posedge clk); #1;
      adjclk = 1'b0; countclk = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (t_a !== 16'h0101) begin fails++; $display("FAIL adj_sec_wrap_a got %h exp 0101", t_a); end
    checks++;
    if (t_b !== 16'h0101) begin fails++; $display("FAIL adj_sec_wrap_b got %h exp 0101", t_b); end
    // Counting alone in adjust mode is ignored.
    cnt_pulse();
    checks++;
    if (t_a !== 16'h0101) begin fails++; $display("FAIL adj_ignore_cnt got %h exp 0101", t_a); end
    adj = 1'b0;
    $display("adjust: digits=%h", t_a);
  endtask

  task automatic test_pause();
    do_reset();
    for (int i = 0; i < 5; i++) cnt_pulse();
    checks++;
    if (t_a !== 16'h0005) begin fails++; $display("FAIL pause_pre got %h exp 0005", t_a); end
    countclk = 1'b1; pause = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (t_a !== 16'h0006) begin fails++; $display("FAIL pause_edge_count got %h exp 0006", t_a); end
    checks++;
    if (a_paused !== 1'b1) begin fails++; $display("FAIL pause_set got %b exp 1", a_paused); end
    countclk = 1'b0; pause = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) cnt_pulse();
    checks++;
    if (t_a !== 16'h0006) begin fails++; $display("FAIL pause_frozen got %h exp 0006", t_a); end
    // Adjust ticks are frozen as well.
    adj = 1'b1; sel = 1'b1;
    adj_pulses(2);
    adj = 1'b0;
    checks++;
    if (t_a !== 16'h0006) begin fails++; $display("FAIL pause_adj_frozen got %h exp 0006", t_a); end
    countclk = 1'b1; pause = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (t_a !== 16'h0006) begin fails++; $display("FAIL unpause_drop got %h exp 0006", t_a); end
    checks++;
    if (a_paused !== 1'b0) begin fails++; $display("FAIL unpause_clr got %b exp 0", a_paused); end
    countclk = 1'b0; pause = 1'b0;
    @(posedge clk); #1;
    cnt_pulse();
    checks++;
    if (t_a !== 16'h0007) begin fails++; $display("FAIL unpause_next got %h exp 0007", t_a); end
    $display("pause: digits=%h paused=%b", t_a, a_paused);
  endtask

  task automatic test_reset_midcount();
    do_reset();
    adj = 1'b1; sel = 1'b0;
    adj_pulses(12);
    sel = 1'b1;
    adj_pulses(34);
    adj = 1'b0;
    checks++;
    if (t_a !== 16'h1234) begin fails++; $display("FAIL mid_preload got %h exp 1234", t_a); end
    countclk = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (t_a !== 16'h0000) begin fails++; $display("FAIL mid_async_clear got %h exp 0000", t_a); end
    checks++;
    if (a_paused !== 1'b0) begin fails++; $display("FAIL mid_paused got %b exp 0", a_paused); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (t_a !== 16'h0001) begin fails++; $display("FAIL mid_first_edge got %h exp 0001", t_a); end
    @(posedge clk); #1;
    checks++;
    if (t_a !== 16'h0001) begin fails++; $display("FAIL mid_level_held got %h exp 0001", t_a); end
    countclk = 1'b0;
    @(posedge clk); #1;
    $display("reset_midcount: digits=%h", t_a);
  endtask

`ifdef STOPWATCH_BLINK_EN
  task automatic test_blink();
    logic [7:0] pat;
    pat = 8'b1011_0010;
    do_reset();
    adj = 1'b1; sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      blinkclk = pat[i];
      @(posedge clk); #1;
      checks++;
      if (a_bsec !== pat[i]) begin fails++; $display("FAIL blink_sec_%0d got %b exp %b", i, a_bsec, pat[i]); end
      checks++;
      if (a_bmin !== 1'b0) begin fails++; $display("FAIL blink_min_%0d got %b exp 0", i, a_bmin); end
    end
    sel = 1'b0; blinkclk = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_bmin !== 1'b1 || a_bsec !== 1'b0) begin
      fails++; $display("FAIL blink_selmin got %b%b exp 10", a_bmin, a_bsec);
    end
    adj = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a_bmin !== 1'b0 || a_bsec !== 1'b0) begin
      fails++; $display("FAIL blink_normal got %b%b exp 00", a_bmin, a_bsec);
    end
    blinkclk = 1'b0;
    $display("blink: blank_min=%b blank_sec=%b", a_bmin, a_bsec);
  endtask
`endif

  initial begin
    test_reset();
    test_count60();
    test_rollover();
    test_adjust();
    test_pause();
    test_reset_midcount();
`ifdef STOPWATCH_BLINK_EN
    test_blink();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
